// File: rtl/fetch_pkg.sv
// Shared types and sizing for the instruction fetch controller.
// Defining FETCH_PREFETCH_EN selects a two-deep prefetch; otherwise one request is in flight.
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

`ifdef FETCH_PREFETCH_EN
    localparam int unsigned FETCH_DEPTH = 2;
`else
    localparam int unsigned FETCH_DEPTH = 1;
`endif

    localparam int unsigned OCC_W = $clog2(FETCH_DEPTH + 1);
    localparam int unsigned CNT_W = 2;

    typedef struct packed {
        logic [ILEN-1:0] ins;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of fetched {instruction, pc} entries; flush empties it and wins over push/pop.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  fetch_entry_t                 push_entry,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: issues in-order memory requests, buffers responses for decode,
// and discards stale responses after a redirect. Depth set by FETCH_PREFETCH_EN (see fetch_pkg).
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [ILEN-1:0] imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            id_valid_o,
    output logic [ILEN-1:0] id_ins_o,
    output logic [XLEN-1:0] id_pc_o,
    input  logic            id_ready_i
);

    fetch_state_e    state_q;
    logic            run_q;
    logic            pend_q;
    logic [XLEN-1:0] pend_pc_q;
    logic [XLEN-1:0] resp_pc_q;
    logic [CNT_W-1:0] out_q;
    logic [CNT_W-1:0] disc_q;

    logic [OCC_W-1:0] occ;
    logic             buf_full;
    logic             buf_empty;
    fetch_entry_t     head;
    fetch_entry_t     push_entry;

    logic             xfer;
    logic             gnt_fire;
    logic             req_held;
    logic             drop;
    logic             push;
    logic             can_issue;
    logic [2:0]       slots;
    logic [2:0]       occ_n;
    logic [2:0]       slots_n;
    logic [CNT_W-1:0] out_n;
    logic [XLEN-1:0]  target;

    // Request may use the slot freed by a same-cycle decode transfer; a held request stays up.
    assign imem_req_o = run_q && ((state_q == ST_REQ) || can_issue);

    always_comb begin
        xfer       = !buf_empty && id_ready_i;
        gnt_fire   = imem_req_o && imem_gnt_i;
        req_held   = imem_req_o && !imem_gnt_i;
        drop       = imem_rvalid_i && (disc_q != '0);
        push       = imem_rvalid_i && !drop && !redirect_i && (!buf_full || xfer);
        slots      = 3'(occ) + 3'(out_q) - 3'(xfer);
        can_issue  = (slots < 3'(FETCH_DEPTH));
        out_n      = out_q + CNT_W'(gnt_fire) - CNT_W'(imem_rvalid_i);
        occ_n      = redirect_i ? 3'd0 : 3'(occ) + 3'(push) - 3'(xfer);
        slots_n    = occ_n + 3'(out_n);
        target     = redirect_pc_i & ~XLEN'(3);
        push_entry = '{ins: imem_rdata_i, pc: resp_pc_q};
    end

    fetch_buffer #(
        .DEPTH(FETCH_DEPTH)
    ) u_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_entry(push_entry),
        .pop       (xfer),
        .flush     (redirect_i),
        .head      (head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (occ)
    );

    assign id_valid_o = !buf_empty;
    assign id_ins_o   = head.ins;
    assign id_pc_o    = head.pc;

    // Bus-side state, address, and outstanding/discard accounting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            run_q       <= 1'b0;
            imem_addr_o <= RESET_PC;
            resp_pc_q   <= RESET_PC;
            pend_q      <= 1'b0;
            pend_pc_q   <= '0;
            out_q       <= '0;
            disc_q      <= '0;
        end else begin
            run_q <= 1'b1;
            out_q <= out_n;

            // Everything still in flight after a redirect belongs to the old stream.
            if (redirect_i) begin
                disc_q <= out_n;
            end else begin
                disc_q <= disc_q - CNT_W'(drop) + CNT_W'(gnt_fire && pend_q);
            end

            if (redirect_i) begin
                pend_q    <= req_held;
                pend_pc_q <= target;
            end else if (gnt_fire) begin
                pend_q <= 1'b0;
            end

            if (redirect_i && !req_held) begin
                imem_addr_o <= target;
            end else if (gnt_fire) begin
                imem_addr_o <= pend_q ? pend_pc_q : imem_addr_o + XLEN'(4);
            end

            if (redirect_i) begin
                resp_pc_q <= target;
            end else if (push) begin
                resp_pc_q <= resp_pc_q + XLEN'(4);
            end

            if (req_held) begin
                state_q <= ST_REQ;
            end else if (slots_n >= 3'(FETCH_DEPTH)) begin
                state_q <= ST_WAIT;
            end else begin
                state_q <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: in-order memory model, expected-PC queue, decode monitor.
module tb_fetch_controller;
    import fetch_pkg::*;

`ifdef FETCH_PREFETCH_EN
    localparam int EXP_GAP = 1;
`else
    localparam int EXP_GAP = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        id_valid_o;
    logic [31:0] id_ins_o;
    logic [31:0] id_pc_o;
    logic        id_ready_i;

    logic [31:0] exp_q [$];
    logic [31:0] gq [$];
    logic [31:0] glog [$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_x = 0;
    int          gcount = 0;
    bit          have_prev = 1'b0;
    bit          gap_en = 1'b0;
    bit          mem_hold = 1'b0;

    fetch_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .id_valid_o   (id_valid_o),
        .id_ins_o     (id_ins_o),
        .id_pc_o      (id_pc_o),
        .id_ready_i   (id_ready_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory: log grants at mid-cycle, answer each one exactly one cycle later, in order.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && imem_req_o && imem_gnt_i) begin
                gq.push_back(imem_addr_o);
                glog.push_back(imem_addr_o);
                gcount++;
            end
        end
    end

    initial begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                gq.delete();
                imem_rvalid_i = 1'b0;
            end else if (!mem_hold && gq.size() > 0) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = mem_word(gq.pop_front());
            end else begin
                imem_rvalid_i = 1'b0;
            end
        end
    end

    // Monitor: bus protocol checks and decode-side scoreboard.
    initial begin
        logic        pr;
        logic [31:0] pa;
        logic [31:0] e;
        pr = 1'b0;
        pa = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                pr = 1'b0;
            end else begin
                if (imem_req_o) check("addr_align", {30'b0, imem_addr_o[1:0]}, 32'h0);
                if (pr) begin
                    check("req_hold", {31'b0, imem_req_o}, 32'h1);
                    check("addr_hold", imem_addr_o, pa);
                end
                pr = imem_req_o && !imem_gnt_i;
                pa = imem_addr_o;
                if (id_valid_o && id_ready_i) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_xfer: got pc %h expected none", id_pc_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("id_pc", id_pc_o, e);
                        check("id_ins", id_ins_o, mem_word(e));
                    end
                    if (gap_en && have_prev) check("xfer_gap", 32'(cyc - last_x), 32'(EXP_GAP));
                    have_prev = 1'b1;
                    last_x    = cyc;
                end
            end
        end
    end

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget && exp_q.size() != 0; k++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: got %0d pending transfers expected 0", exp_q.size());
            exp_q.delete();
        end
        id_ready_i = 1'b0;
        gap_en     = 1'b0;
    endtask

    // Asynchronous reset mid-cycle; outputs must take reset values without waiting for a clock.
    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_req", {31'b0, imem_req_o}, 32'h0);
        check("rst_addr", imem_addr_o, DEFAULT_RESET_PC);
        check("rst_valid", {31'b0, id_valid_o}, 32'h0);
        check("rst_ins", id_ins_o, 32'h0);
        check("rst_pc", id_pc_o, 32'h0);
        imem_gnt_i = 1'b0;
        id_ready_i = 1'b0;
        redirect_i = 1'b0;
        mem_hold   = 1'b0;
        repeat (2) @(negedge clk);
        gq.delete();
        glog.delete();
        gcount    = 0;
        have_prev = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        imem_gnt_i    = 1'b0;
        id_ready_i    = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        repeat (2) @(negedge clk);
        do_reset();

        // Streaming with ideal memory and decode.
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        gap_en = 1'b1;
        imem_gnt_i = 1'b1;
        id_ready_i = 1'b1;
        rst_n      = 1'b1;
        @(negedge clk);
        check("first_req", {31'b0, imem_req_o}, 32'h1);
        check("first_addr", imem_addr_o, DEFAULT_RESET_PC);
        wait_done(100);
        check("stream_glog0", glog[0], 32'h0);
        do_reset();

        // Decode stalled for 10 cycles: request drops at capacity, then resumes in order.
        for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
        imem_gnt_i = 1'b1;
        rst_n      = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #2;
        end
        @(negedge clk);
        check("cap_req", {31'b0, imem_req_o}, 32'h0);
        check("cap_valid", {31'b0, id_valid_o}, 32'h1);
        check("cap_head", id_pc_o, 32'h0);
        check("cap_grants", 32'(gcount), 32'(FETCH_DEPTH));
        @(posedge clk);
        #2;
        id_ready_i = 1'b1;
        wait_done(100);
        do_reset();

        // Redirect with all slots outstanding: stale responses dropped.
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + 32'(i * 4));
        mem_hold   = 1'b1;
        imem_gnt_i = 1'b1;
        id_ready_i = 1'b1;
        rst_n      = 1'b1;
        for (int k = 0; k < 50 && gcount < int'(FETCH_DEPTH); k++) begin
            @(posedge clk);
            #2;
        end
        check("pre_redirect_grants", 32'(gcount), 32'(FETCH_DEPTH));
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        @(posedge clk);
        #2;
        redirect_i = 1'b0;
        mem_hold   = 1'b0;
        wait_done(100);
        do_reset();

        // Grant withheld 5 cycles with a misaligned redirect while the request waits.
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h200 + 32'(i * 4));
        id_ready_i = 1'b1;
        rst_n      = 1'b1;
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h203;
        @(posedge clk);
        #2;
        redirect_i = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #2;
        end
        imem_gnt_i = 1'b1;
        wait_done(100);
        check("held_grant_addr", glog[0], 32'h0);
        check("after_held_addr", glog[1], 32'h200);
        do_reset();

        // Address wrap at the top of the address space.
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFB;
        imem_gnt_i    = 1'b1;
        id_ready_i    = 1'b1;
        rst_n         = 1'b1;
        @(posedge clk);
        #2;
        redirect_i = 1'b0;
        wait_done(100);
        check("wrap_addr0", glog[0], 32'hFFFF_FFF8);
        check("wrap_addr2", glog[2], 32'h0000_0000);
        do_reset();

        // Redirect in the same cycle as a transfer: head delivered, rest flushed.
        exp_q.push_back(32'h0);
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h40 + 32'(i * 4));
        imem_gnt_i = 1'b1;
        rst_n      = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #2;
        end
        id_ready_i    = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h40;
        @(posedge clk);
        #2;
        redirect_i = 1'b0;
        @(negedge clk);
        check("flush_valid", {31'b0, id_valid_o}, 32'h0);
        wait_done(100);
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
